// File: rtl/redux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : redux_pkg                                                |
// | Shared PC width, sequencer state encoding and next-PC select codes.|
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package redux_pkg;

    localparam int PC_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4,
        FAULT  = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        SEQ = 2'd0,
        REL = 2'd1,
        ABS = 2'd2
    } npc_sel_t;

    // Absolute branch outranks a relative jump when both are requested.
    function automatic npc_sel_t npc_select(input logic jmx, input logic bmx);
        if (bmx)
            return ABS;
        else if (jmx)
            return REL;
        else
            return SEQ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface : pc_sequencer_if                                        |
// | Instruction-memory fetch handshake between sequencer and memory.   |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
interface pc_sequencer_if;
    import redux_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [7:0]      imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );

endinterface
`default_nettype wire

// File: rtl/next_pc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : next_pc                                                   |
// | Combinational next-PC: sequential, signed relative or absolute.    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module next_pc
    import redux_pkg::*;
(
    input  wire logic [PC_W-1:0] curPC,
    input  wire logic [PC_W-1:0] imm,
    input  wire logic [PC_W-1:0] b,
    input  wire logic            jmx,
    input  wire logic            bmx,
    output logic      [PC_W-1:0] pc
);

    npc_sel_t w_sel;

    // imm is as wide as the PC, so a plain modulo-256 add equals pc+sign_ext(imm).
    always_comb begin
        w_sel = npc_select(jmx, bmx);
        pc    = curPC + PC_W'(1);
        unique case (w_sel)
            SEQ:     pc = curPC + PC_W'(1);
            REL:     pc = curPC + imm;
            ABS:     pc = b;
            default: pc = curPC + PC_W'(1);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : pc_sequencer                                              |
// | Fetch/decode/execute program-counter sequencer with fetch timeout. |
// | Option : define PC_SEQ_RETIRE_CNT_EN for a saturating retired count|
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module pc_sequencer
    import redux_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC     = 8'd0,
    parameter int              IMEM_TIMEOUT = 15
)(
    input  wire logic            clk,
    input  wire logic            rst,
    pc_sequencer_if.master       bus,
    output logic [7:0]           instr,
    output logic                 instr_valid,
    input  wire logic            exec_done,
    input  wire logic            jmp,
    input  wire logic            br_taken,
    input  wire logic [PC_W-1:0] imm,
    input  wire logic [PC_W-1:0] b,
    input  wire logic            halt,
    output logic [PC_W-1:0]      pc,
    output logic                 fault,
    output logic                 halted
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]          retired
`endif
);

    localparam logic [15:0] c_timeout = 16'(IMEM_TIMEOUT);

    seq_state_t      r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_instr;
    logic            r_valid;
    logic            r_req;
    logic            r_fault;
    logic            r_halted;
    logic [15:0]     r_tcnt;
    logic [PC_W-1:0] w_npc;
    logic            w_jmx;
    logic            w_bmx;

    assign w_jmx = jmp;
    assign w_bmx = br_taken;

    next_pc u_next_pc (
        .curPC (r_pc),
        .imm   (imm),
        .b     (b),
        .jmx   (w_jmx),
        .bmx   (w_bmx),
        .pc    (w_npc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_instr  <= 8'd0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
            r_fault  <= 1'b0;
            r_halted <= 1'b0;
            r_tcnt   <= 16'd0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_tcnt  <= 16'd0;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        r_instr <= bus.imem_data;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= DECODE;
                    end else if ((c_timeout != 16'd0) && (r_tcnt + 16'd1 == c_timeout)) begin
                        // This cycle is the last unacknowledged one allowed.
                        r_state <= FAULT;
                        r_req   <= 1'b0;
                        r_fault <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
                DECODE: r_state <= EXEC;
                EXEC: begin
                    if (exec_done) begin
                        r_pc <= w_npc;
                        if (halt) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                            r_tcnt  <= 16'd0;
                        end
                    end
                end
                HALTED, FAULT: r_state <= r_state;
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] r_retired;

    always_ff @(posedge clk) begin
        if (rst)
            r_retired <= 16'd0;
        else if ((r_state == EXEC) && exec_done && (r_retired != 16'hFFFF))
            r_retired <= r_retired + 16'd1;
    end

    assign retired = r_retired;
`endif

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign instr         = r_instr;
    assign instr_valid   = r_valid;
    assign pc            = r_pc;
    assign fault         = r_fault;
    assign halted        = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_pc_sequencer                                           |
// | Directed, table-driven self-checking bench for pc_sequencer.       |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr;
    logic       instr_valid;
    logic       exec_done = 1'b0;
    logic       jmp = 1'b0;
    logic       br_taken = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] imm = 8'd0;
    logic [7:0] b = 8'd0;
    logic [7:0] pc;
    logic       fault;
    logic       halted;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    int         checks = 0;
    int         errors = 0;
    int         exp_ret = 0;
    logic [7:0] cur_pc = 8'd0;

    pc_sequencer_if bus();

    pc_sequencer #(
        .RESET_PC     (8'd0),
        .IMEM_TIMEOUT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .instr       (instr),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .jmp         (jmp),
        .br_taken    (br_taken),
        .imm         (imm),
        .b           (b),
        .halt        (halt),
        .pc          (pc),
        .fault       (fault),
        .halted      (halted)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retired     (retired)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       j;
        logic       br;
        logic [7:0] im;
        logic [7:0] bb;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_retired();
`ifdef PC_SEQ_RETIRE_CNT_EN
        chk("retired", retired, 16'(exp_ret));
`endif
    endtask

    task automatic wait_req();
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            checks++;
            errors++;
            $display("FAIL wait_req: imem_req stayed %b, expected 1 within 20 cycles", bus.imem_req);
        end
    endtask

    task automatic do_instr(input logic [7:0] data, input logic j, input logic br,
                            input logic h, input logic [7:0] im, input logic [7:0] bb);
        wait_req();
        chk("fetch_addr", bus.imem_addr, cur_pc);
        bus.imem_ack  = 1'b1;
        bus.imem_data = data;
        tick();
        bus.imem_ack  = 1'b0;
        chk("instr_load", instr, data);
        chk("valid_pulse", instr_valid, 1'b1);
        tick();
        chk("valid_drop", instr_valid, 1'b0);
        exec_done = 1'b1;
        jmp       = j;
        br_taken  = br;
        halt      = h;
        imm       = im;
        b         = bb;
        tick();
        exec_done = 1'b0;
        jmp       = 1'b0;
        br_taken  = 1'b0;
        halt      = 1'b0;
        exp_ret++;
        chk_retired();
    endtask

    initial begin
        vecs[0] = '{8'h01, 1'b0, 1'b0, 8'h00, 8'd0,   8'd121};
        vecs[1] = '{8'h02, 1'b1, 1'b0, 8'd6,  8'd0,   8'd127};
        vecs[2] = '{8'h03, 1'b0, 1'b1, 8'h00, 8'd55,  8'd55};
        vecs[3] = '{8'h04, 1'b0, 1'b1, 8'h00, 8'd0,   8'd0};
        vecs[4] = '{8'h05, 1'b1, 1'b0, 8'hFC, 8'd0,   8'd252};
        vecs[5] = '{8'h06, 1'b0, 1'b1, 8'h00, 8'd255, 8'd255};
        vecs[6] = '{8'h07, 1'b0, 1'b0, 8'h00, 8'd0,   8'd0};
        vecs[7] = '{8'h08, 1'b1, 1'b1, 8'd3,  8'd55,  8'd55};
        vecs[8] = '{8'h09, 1'b1, 1'b0, 8'h80, 8'd0,   8'd183};
        vecs[9] = '{8'h0A, 1'b1, 1'b0, 8'h7F, 8'd0,   8'd54};

        bus.imem_ack  = 1'b0;
        bus.imem_data = 8'd0;

        // Reset state
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_pc", pc, 8'd0);
        chk("rst_instr", instr, 8'd0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_req", bus.imem_req, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk_retired();

        // First fetch acknowledged immediately
        rst = 1'b0;
        tick();
        chk("first_req", bus.imem_req, 1'b1);
        chk("first_addr", bus.imem_addr, 8'd0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'hA5;
        tick();
        chk("a5_instr", instr, 8'hA5);
        chk("a5_valid", instr_valid, 1'b1);
        chk("a5_pc", pc, 8'd0);
        chk("a5_req_drop", bus.imem_req, 1'b0);
        // Ack during DECODE must not reload instr
        bus.imem_data = 8'h11;
        tick();
        bus.imem_ack = 1'b0;
        chk("a5_valid_once", instr_valid, 1'b0);
        chk("ack_ignored", instr, 8'hA5);
        exec_done = 1'b1;
        br_taken  = 1'b1;
        b         = 8'd120;
        tick();
        exec_done = 1'b0;
        br_taken  = 1'b0;
        exp_ret++;
        chk("br120_pc", pc, 8'd120);
        chk("loop_req", bus.imem_req, 1'b1);
        chk_retired();
        cur_pc = 8'd120;

        // Next-PC table
        for (int i = 0; i < 10; i++) begin
            do_instr(vecs[i].data, vecs[i].j, vecs[i].br, 1'b0, vecs[i].im, vecs[i].bb);
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            cur_pc = vecs[i].exp_pc;
        end

        // Reset in FETCH with a coincident ack
        wait_req();
        rst           = 1'b1;
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h3C;
        tick();
        rst          = 1'b0;
        bus.imem_ack = 1'b0;
        exp_ret      = 0;
        cur_pc       = 8'd0;
        chk("rstack_pc", pc, 8'd0);
        chk("rstack_instr", instr, 8'd0);
        chk("rstack_valid", instr_valid, 1'b0);
        chk("rstack_req", bus.imem_req, 1'b0);
        chk_retired();
        tick();
        chk("rstack_valid2", instr_valid, 1'b0);
        chk("rstack_refetch", bus.imem_req, 1'b1);

        // Fetch timeout: FAULT after the 15th unacknowledged FETCH cycle
        repeat (14) tick();
        chk("to_req_14", bus.imem_req, 1'b1);
        chk("to_fault_14", fault, 1'b0);
        tick();
        chk("to_fault", fault, 1'b1);
        chk("to_req", bus.imem_req, 1'b0);
        bus.imem_ack  = 1'b1;
        bus.imem_data = 8'h77;
        repeat (5) tick();
        bus.imem_ack = 1'b0;
        chk("to_sticky", fault, 1'b1);
        chk("to_req_stay", bus.imem_req, 1'b0);
        chk("to_instr", instr, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("to_clear", fault, 1'b0);
        tick();

        // Halt at pc=10
        do_instr(8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 8'd10);
        chk("pre_halt_pc", pc, 8'd10);
        cur_pc = 8'd10;
        do_instr(8'h21, 1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        chk("halt_pc", pc, 8'd11);
        chk("halt_flag", halted, 1'b1);
        chk("halt_req", bus.imem_req, 1'b0);
        exec_done = 1'b1;
        repeat (4) tick();
        exec_done = 1'b0;
        chk("halt_stay_req", bus.imem_req, 1'b0);
        chk("halt_stay", halted, 1'b1);
        chk("halt_stay_pc", pc, 8'd11);
        chk_retired();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'd0, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_TIMEOUT, default 15, maximum unacknowledged fetch cycles; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  8  fetch address, always equal to pc.
REQ-007 SHALL have port imem_ack  input  1  memory acknowledge; imem_data is valid in that cycle.
REQ-008 SHALL have port imem_data  input  8  fetched instruction byte.
REQ-009 SHALL have port instr  output  8  instruction register.
REQ-010 SHALL have port instr_valid  output  1  one-cycle pulse, instr newly loaded.
REQ-011 SHALL have port exec_done  input  1  datapath has finished executing instr.
REQ-012 SHALL have port jmp  input  1  relative jump request, qualified by exec_done.
REQ-013 SHALL have port br_taken  input  1  absolute branch taken, qualified by exec_done.
REQ-014 SHALL have port imm  input  8  signed two's-complement jump offset.
REQ-015 SHALL have port b  input  8  absolute branch target (register value).
REQ-016 SHALL have port halt  input  1  stop after the current instruction, qualified by exec_done.
REQ-017 SHALL have port pc  output  8  registered program counter.
REQ-018 SHALL have port fault  output  1  sticky fetch-timeout flag.
REQ-019 SHALL have port halted  output  1  high while in HALTED.

Function
REQ-020 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALTED, FAULT.
REQ-021 Transitions: IDLE->FETCH unconditionally after one cycle; FETCH->DECODE on imem_ack; DECODE->EXEC always; EXEC->FETCH on exec_done with halt=0; EXEC->HALTED on exec_done with halt=1; FETCH->FAULT on timeout. HALTED and FAULT SHALL exit only through rst.
REQ-022 imem_req SHALL be registered and high in FETCH only; imem_ack SHALL be ignored outside FETCH.
REQ-023 On the edge where imem_ack=1 in FETCH, instr SHALL load imem_data; instr_valid SHALL be high for exactly the following cycle (DECODE).
REQ-024 On the edge where exec_done=1 in EXEC, pc SHALL load the next PC: br_taken=1 -> b; else jmp=1 -> pc+sign_ext(imm); else pc+1.
REQ-025 br_taken SHALL take priority over jmp when both are high.
REQ-026 All PC arithmetic SHALL be modulo 256: 255+1 -> 0, 0+(-4) -> 252.
REQ-027 With halt=1, pc SHALL still update per REQ-024 before entering HALTED.
REQ-028 The timeout counter SHALL clear on FETCH entry and increment each FETCH cycle without ack; when it equals IMEM_TIMEOUT, the FSM SHALL go to FAULT, imem_req SHALL go to 0, and fault SHALL go to 1.
REQ-029 The minimum loop from FETCH to the next FETCH, with ack and exec_done each in their first cycle, SHALL be 3 cycles.

Reset
REQ-030 rst=1 at any clock edge, including mid-fetch or mid-exec, SHALL force IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fault=0, halted=0, and clear all counters; an imem_ack coincident with rst SHALL be ignored.

Configuration
REQ-031 Macro PC_SEQ_RETIRE_CNT_EN defined: add output retired [15:0], reset to 0, incrementing on every exec_done accepted in EXEC and saturating at 65535.
REQ-032 Macro PC_SEQ_RETIRE_CNT_EN undefined: no retired port and no counter logic.

Structure
REQ-033 Shared package redux_pkg SHALL hold the FSM state enum, the next-PC select encoding (SEQ, REL, ABS) and PC_W=8.
REQ-034 Next-PC arithmetic SHALL be the existing next_pc sub-module (curPC, imm, b, jmx, bmx -> pc), instantiated once; jmx and bmx SHALL be derived from jmp and br_taken.

Verification
REQ-035 rst, then ack in the first FETCH cycle with data 8'hA5 -> instr=8'hA5, instr_valid pulses once, pc=0.
REQ-036 pc=120, exec_done with no jmp or branch -> pc=121; then jmp=1, imm=6 -> pc=127; then br_taken=1, b=55 -> pc=55.
REQ-037 pc=0, jmp=1, imm=-4 -> pc=252; pc=255, sequential step -> pc=0; jmp=1 and br_taken=1 with b=55 -> pc=55.
REQ-038 No ack for 15 FETCH cycles -> fault=1, imem_req=0, FSM stays in FAULT until rst.
REQ-039 rst asserted in FETCH with a coincident ack -> next cycle state=IDLE, pc=RESET_PC, instr=0, instr_valid never pulses.
REQ-040 exec_done with halt=1 at pc=10 -> pc=11, halted=1, no further imem_req; with PC_SEQ_RETIRE_CNT_EN defined, retired counts retired instructions correctly.
